store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/mem_pkg.sv | 15 +
 rtl/store_lane_fmt.sv | 46 ++++
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-access definitions.
// Holds the store-size encodings used on st_size and the default depth of
// the store buffer, so the buffer and its lane formatter agree on them.
package mem_pkg;

  // Store access sizes; 2'b11 is reserved and always rejected.
  localparam logic [1:0] SZ_W   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_B   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  // Default number of buffered store entries.
  localparam int SB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/store_lane_fmt.sv
// Store lane formatter and legality check (purely combinational).
// Ports:
//   i_addr_lo [1:0] : byte offset of the store within its word
//   i_data    [31:0]: raw register data, used bytes start at bit 0
//   i_size    [1:0] : SZ_W / SZ_H / SZ_B (11 reserved)
//   o_legal         : store is naturally aligned and has a valid size
//   o_wdata   [31:0]: data replicated into every lane it could occupy
//   o_be      [3:0] : byte enables, bit n selects byte n
module store_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  output logic        o_legal,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be
);

  always_comb begin
    o_legal = 1'b0;
    o_wdata = '0;
    o_be    = '0;
    case (i_size)
      SZ_B: begin
        o_legal = 1'b1;
        o_wdata = {4{i_data[7:0]}};
        o_be    = 4'b0001 << i_addr_lo;
      end
      SZ_H: begin
        o_legal = ~i_addr_lo[0];
        o_wdata = {2{i_data[15:0]}};
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W: begin
        o_legal = (i_addr_lo == 2'b00);
        o_wdata = i_data;
        o_be    = 4'b1111;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: a strict FIFO of formatted stores draining to data memory.
// Ports:
//   clk, reset (async, active-low)
//   st_valid/st_addr/st_data/st_size -> store request; st_ready, st_err
//   ld_valid/ld_addr -> load probe; ld_stall when the load's word is buffered
//   dm_wr_en/dm_addr/dm_wdata/dm_be -> head-of-queue write; dm_ready accepts it
//   count -> number of valid entries
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_stall,
  output logic                     dm_wr_en,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [3:0]               dm_be,
  input  logic                     dm_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  logic             r_err;

  // Entry payload; no reset needed because r_valid/r_count gate every use.
  logic [29:0]      r_ent_addr  [DEPTH];
  logic [31:0]      r_ent_wdata [DEPTH];
  logic [3:0]       r_ent_be    [DEPTH];

  logic             w_legal;
  logic [31:0]      w_fmt_wdata;
  logic [3:0]       w_fmt_be;
  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;
  logic             w_new_match;
  logic             w_unused_ld_lo;

  store_lane_fmt u_fmt (
    .i_addr_lo (st_addr[1:0]),
    .i_data    (st_data),
    .i_size    (st_size),
    .o_legal   (w_legal),
    .o_wdata   (w_fmt_wdata),
    .o_be      (w_fmt_be)
  );

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Full blocks enqueue even if the head pops this cycle. The reset term keeps
  // an incoming store from being seen as accepted while reset is held.
  assign w_enq   = reset & st_valid & ~w_full & w_legal;
  assign w_pop   = ~w_empty & dm_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= st_valid & ~w_legal;
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Enqueue never targets the popped slot: a pop needs a non-empty queue
      // and an enqueue needs a non-full one, so the pointers differ.
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_enq) begin
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_ent_addr[r_wr_ptr]  <= st_addr[31:2];
      r_ent_wdata[r_wr_ptr] <= w_fmt_wdata;
      r_ent_be[r_wr_ptr]    <= w_fmt_be;
    end
  end

  // Word-address match of the load against every valid entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_match[gi] = r_valid[gi] & (r_ent_addr[gi] == ld_addr[31:2]);
    end
  endgenerate

  assign w_new_match    = w_enq & (st_addr[31:2] == ld_addr[31:2]);
  assign ld_stall       = reset & ld_valid & ((|w_match) | w_new_match);
  assign w_unused_ld_lo = ^ld_addr[1:0];

  assign st_ready = ~w_full;
  assign st_err   = r_err;
  assign count    = r_count;
  assign dm_wr_en = ~w_empty;
  assign dm_addr  = w_empty ? 32'h0 : {r_ent_addr[r_rd_ptr], 2'b00};
  assign dm_wdata = w_empty ? 32'h0 : r_ent_wdata[r_rd_ptr];
  assign dm_be    = w_empty ? 4'h0  : r_ent_be[r_rd_ptr];

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        st_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        dm_wr_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_size  (st_size),
    .st_ready (st_ready),
    .st_err   (st_err),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_stall (ld_stall),
    .dm_wr_en (dm_wr_en),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_ready (dm_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending word writes.
  typedef struct {
    logic [29:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;
  vec_t tv[8];

  // Access of n bytes at offset off: legal when off is a multiple of n;
  // lane k is enabled when it lies in [off, off+n) and carries data byte k%n.
  function automatic void model_fmt(input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] sz, output logic ok,
                                    output ent_t e);
    int n;
    int off;
    e.wa = a[31:2];
    e.wd = '0;
    e.be = '0;
    ok   = 1'b0;
    n    = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 0;
    off  = int'(a[1:0]);
    if (n != 0 && (off % n) == 0) begin
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        e.wd[8*k +: 8] = d[8*(k % n) +: 8];
        e.be[k]        = (k >= off) && (k < off + n);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle with the current inputs, checked against the model
  // before the edge (combinational view) and after it (registered view).
  task automatic cyc();
    logic ok;
    ent_t e;
    logic acc;
    logic stall;
    logic exp_err;
    #1;
    model_fmt(st_addr, st_data, st_size, ok, e);
    acc   = st_valid && (q.size() != DEPTH) && ok;
    stall = 1'b0;
    if (ld_valid) begin
      foreach (q[i]) if (q[i].wa == ld_addr[31:2]) stall = 1'b1;
      if (acc && e.wa == ld_addr[31:2]) stall = 1'b1;
    end
    chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
    chk("ld_stall", 32'(ld_stall), 32'(stall));
    chk("count_pre", 32'(count), 32'(q.size()));
    if (q.size() == 0) begin
      chk("dm_wr_en", 32'(dm_wr_en), 32'd0);
      chk("dm_addr", dm_addr, 32'd0);
      chk("dm_wdata", dm_wdata, 32'd0);
      chk("dm_be", 32'(dm_be), 32'd0);
    end else begin
      chk("dm_wr_en", 32'(dm_wr_en), 32'd1);
      chk("dm_addr", dm_addr, {q[0].wa, 2'b00});
      chk("dm_wdata", dm_wdata, q[0].wd);
      chk("dm_be", 32'(dm_be), 32'(q[0].be));
    end
    exp_err = st_valid && !ok;
    @(posedge clk);
    if (q.size() != 0 && dm_ready) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      $display("txn store addr=%h be=%b wdata=%h count=%0d", st_addr, e.be, e.wd, q.size());
    end else if (st_valid) begin
      $display("txn store addr=%h size=%b not accepted (illegal=%0d)", st_addr, st_size, !ok);
    end
    #1;
    chk("st_err", 32'(st_err), 32'(exp_err));
    chk("count_post", 32'(count), 32'(q.size()));
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
  endtask

  initial begin
    tv[0] = '{32'h0000_0013, 32'h0000_00A5, 2'b10, 1'b0, 4'b1000, 32'hA5A5_A5A5};
    tv[1] = '{32'h0000_0021, 32'h0000_1234, 2'b01, 1'b1, 4'b0000, 32'h0000_0000};
    tv[2] = '{32'h0000_0022, 32'hBEEF_1234, 2'b01, 1'b0, 4'b1100, 32'h1234_1234};
    tv[3] = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    tv[4] = '{32'h0000_0102, 32'h1111_2222, 2'b00, 1'b1, 4'b0000, 32'h0000_0000};
    tv[5] = '{32'h0000_0008, 32'h0000_0011, 2'b11, 1'b1, 4'b0000, 32'h0000_0000};
    tv[6] = '{32'h0000_0044, 32'hFFFF_00C3, 2'b10, 1'b0, 4'b0001, 32'hC3C3_C3C3};
    tv[7] = '{32'h0000_0030, 32'h0000_ABCD, 2'b01, 1'b0, 4'b0011, 32'hABCD_ABCD};

    // Reset state, with a legal store and matching load offered.
    reset    = 1'b0;
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h1; st_size = 2'b00;
    ld_valid = 1'b1; ld_addr = 32'h40; dm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_st_err", 32'(st_err), 32'd0);
    chk("rst_dm_wr_en", 32'(dm_wr_en), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    st_valid = 1'b0; ld_valid = 1'b0;
    reset    = 1'b1;

    // Table-driven lane formatting / legality, drained with dm_ready=1.
    dm_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(tv[i].a, tv[i].d, tv[i].sz);
      cyc();
      chk("tv_err", 32'(st_err), 32'(tv[i].err));
      chk("tv_wr_en", 32'(dm_wr_en), 32'(!tv[i].err));
      chk("tv_addr", dm_addr, tv[i].err ? 32'd0 : {tv[i].a[31:2], 2'b00});
      chk("tv_be", 32'(dm_be), 32'(tv[i].be));
      chk("tv_wdata", dm_wdata, tv[i].wd);
      $display("txn vec %0d addr=%h size=%b -> err=%0d be=%b wdata=%h",
               i, tv[i].a, tv[i].sz, st_err, dm_be, dm_wdata);
      st_valid = 1'b0;
      cyc();
      chk("tv_err_clear", 32'(st_err), 32'd0);
      chk("tv_empty", 32'(count), 32'd0);
    end

    // Fill to full with memory stalled, reject a 5th, then drain in order.
    dm_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(32'(4 * k), 32'h100 + 32'(k), 2'b00);
      cyc();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    put(32'h10, 32'h999, 2'b00);
    cyc();
    chk("full_reject", 32'(count), 32'd4);
    st_valid = 1'b0;
    dm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", dm_addr, 32'(4 * k));
      chk("drain_data", dm_wdata, 32'h100 + 32'(k));
      cyc();
    end
    chk("drained", 32'(dm_wr_en), 32'd0);

    // Load hazard against a buffered word.
    dm_ready = 1'b0;
    put(32'h40, 32'h4040_4040, 2'b00);
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h42;
    repeat (3) begin
      cyc();
      chk("ld_hit", 32'(ld_stall), 32'd1);
    end
    ld_addr = 32'h44;
    #1;
    chk("ld_miss", 32'(ld_stall), 32'd0);
    ld_addr  = 32'h42;
    dm_ready = 1'b1;
    cyc();
    chk("ld_after_pop", 32'(ld_stall), 32'd0);
    ld_valid = 1'b0;

    // Simultaneous enqueue and pop at count=2 across pointer wrap.
    dm_ready = 1'b0;
    put(32'h200, 32'hA0, 2'b00); cyc();
    put(32'h204, 32'hA1, 2'b00); cyc();
    dm_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      put(32'h208 + 32'(4 * k), 32'hB0 + 32'(k), 2'b00);
      cyc();
      chk("steady_count", 32'(count), 32'd2);
      chk("steady_head", dm_addr, 32'h200 + 32'(4 * (k + 1)));
    end
    st_valid = 1'b0;
    repeat (2) cyc();

    // Reset asserted mid-cycle with three entries buffered.
    dm_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(32'h300 + 32'(k), 32'(k), 2'b10);
      cyc();
    end
    #2;
    reset    = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h300;
    put(32'h300, 32'h5, 2'b00);
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_wr_en", 32'(dm_wr_en), 32'd0);
    chk("mid_rst_addr", dm_addr, 32'd0);
    chk("mid_rst_wdata", dm_wdata, 32'd0);
    chk("mid_rst_be", 32'(dm_be), 32'd0);
    chk("mid_rst_ready", 32'(st_ready), 32'd1);
    chk("mid_rst_stall", 32'(ld_stall), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    chk("rst_no_enq", 32'(count), 32'd0);
    #2;
    st_valid = 1'b0; ld_valid = 1'b0; dm_ready = 1'b1;
    reset    = 1'b1;
    repeat (4) begin
      cyc();
      chk("post_rst_idle", 32'(dm_wr_en), 32'd0);
    end

    // Randomized traffic against the model.
    repeat (400) begin
      st_valid = 1'(($urandom % 10) < 6);
      st_addr  = 32'($urandom_range(0, 63));
      st_data  = $urandom;
      st_size  = 2'($urandom_range(0, 3));
      dm_ready = 1'($urandom % 2);
      ld_valid = 1'($urandom % 2);
      ld_addr  = 32'($urandom_range(0, 63));
      cyc();
    end
    st_valid = 1'b0; ld_valid = 1'b0; dm_ready = 1'b1;
    repeat (DEPTH + 1) cyc();
    chk("final_empty", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
